// File: rtl/mf_ctrl_pkg.sv
// ============================================================================
//  Module   : mf_ctrl_pkg
//  Purpose  : Shared types and constants for the matched-filter peak
//             sync controller (state encoding, magnitude width helper).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mf_ctrl_pkg;

    // Controller states; encoding is visible on state_o.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        TRACK = 2'd2,
        TWIN  = 2'd3
    } state_t;

    // Default MF output width and the matching |Re|+|Im| width.
    localparam int W3_DEF = 32;
    localparam int MAG_W  = W3_DEF + 1;

    // |Re|+|Im| needs one bit more than a single MF output.
    function automatic int mag_width(input int w3);
        return w3 + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mf_mag_abs.sv
// ============================================================================
//  Module   : mf_mag_abs
//  Purpose  : Registered |re|+|im| of the signed MF outputs, with the MF
//             output-valid delayed by the same single register stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mf_mag_abs
    import mf_ctrl_pkg::*;
#(
    parameter int W3 = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W3-1:0] y_re,
    input  logic [W3-1:0] y_im,
    input  logic          in_v,
    output logic [W3:0]   mag,
    output logic          mag_v
);

    localparam logic [W3-1:0] ONE_C = {{(W3-1){1'b0}}, 1'b1};

    logic [W3-1:0] w_re_abs;
    logic [W3-1:0] w_im_abs;
    logic [W3:0]   mag_d;
    logic [W3:0]   mag_q;
    logic          mag_v_q;

    // Two's-complement absolute values; the most negative input maps to
    // 2^(W3-1), which still fits as an unsigned W3-bit value.
    always_comb begin
        w_re_abs = y_re[W3-1] ? (~y_re + ONE_C) : y_re;
        w_im_abs = y_im[W3-1] ? (~y_im + ONE_C) : y_im;
        mag_d    = {1'b0, w_re_abs} + {1'b0, w_im_abs};
    end

    // Single pipeline stage for magnitude and its valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q   <= '0;
            mag_v_q <= 1'b0;
        end else begin
            mag_q   <= mag_d;
            mag_v_q <= in_v;
        end
    end

    assign mag   = mag_q;
    assign mag_v = mag_v_q;

endmodule

`default_nettype wire

// File: rtl/mf_peak_sync_ctrl.sv
// ============================================================================
//  Module   : mf_peak_sync_ctrl
//  Purpose  : Sequencer for the Re/Im 1-bit matched-filter pair. Gates the
//             MF enable, acquires the first correlation peak above threshold
//             and then tracks the periodic peak in a +/-WIN window around
//             each expected frame position, pulsing sync per located peak.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mf_peak_sync_ctrl
    import mf_ctrl_pkg::*;
#(
    parameter int W3        = 32,
    parameter int FRAME_LEN = 4096,
    parameter int WIN       = 16,
    parameter int MISS_MAX  = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             x_valid,
    output logic             mf_en,
    input  logic [W3:0]      thresh,
    input  logic [W3-1:0]    y_re,
    input  logic [W3-1:0]    y_im,
    input  logic             mf_en_o,
    output logic             sync,
    output logic [W3:0]      peak_mag,
    output logic [CNT_W-1:0] peak_off,
    output logic             locked,
    output logic [1:0]       state_o
);

    localparam int MAG_BITS = mag_width(W3);
    localparam int MISS_W   = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

    localparam logic [CNT_W-1:0]  WIN_C       = CNT_W'(WIN);
    localparam logic [CNT_W-1:0]  TWIN_LEN_C  = CNT_W'(2 * WIN + 1);
    // Last TRACK sample sits one before FRAME_LEN-WIN so that the sample at
    // distance FRAME_LEN-WIN from the last peak opens the window, centring
    // the 2*WIN+1 samples on the expected peak.
    localparam logic [CNT_W-1:0]  TRACK_END_C = CNT_W'(FRAME_LEN - WIN - 1);
    localparam logic [MISS_W-1:0] MISS_C      = MISS_W'(MISS_MAX);

    // Parameter sanity: counters must hold FRAME_LEN+WIN and the tracking
    // window must fit inside one frame.
    if (64'(FRAME_LEN + WIN) >= (64'd1 << CNT_W)) begin : g_err_cnt_w
        $error("mf_peak_sync_ctrl: CNT_W too small for FRAME_LEN+WIN");
    end
    if ((WIN < 1) || (MISS_MAX < 1) || (FRAME_LEN <= 3 * WIN + 1)) begin : g_err_cfg
        $error("mf_peak_sync_ctrl: illegal WIN/MISS_MAX/FRAME_LEN combination");
    end

    logic [MAG_BITS-1:0] w_mag;
    logic                w_mag_v;

    mf_mag_abs #(
        .W3 (W3)
    ) u_mag (
        .clk   (clk),
        .rst_n (rst_n),
        .y_re  (y_re),
        .y_im  (y_im),
        .in_v  (mf_en_o),
        .mag   (w_mag),
        .mag_v (w_mag_v)
    );

    state_t              state_q,    state_d;
    logic                pk_q,       pk_d;
    logic                found_q,    found_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [CNT_W-1:0]    wcnt_q,     wcnt_d;
    logic [CNT_W-1:0]    off_q,      off_d;
    logic [W3:0]         best_q,     best_d;
    logic [MISS_W-1:0]   miss_q,     miss_d;
    logic                sync_q,     sync_d;
    logic [W3:0]         peak_mag_q, peak_mag_d;
    logic [CNT_W-1:0]    peak_off_q, peak_off_d;
    logic                locked_q,   locked_d;

    logic                w_hit;
    logic                w_better;
    logic                w_acq_close;
    logic [CNT_W-1:0]    w_wcnt_inc;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [CNT_W-1:0]    w_off_inc;
    logic [MISS_W-1:0]   w_miss_inc;

    // Next-state and datapath decisions; every decision is qualified by the
    // registered magnitude valid so gaps freeze all counters.
    always_comb begin
        state_d     = state_q;
        pk_d        = pk_q;
        found_d     = found_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        off_d       = off_q;
        best_d      = best_q;
        miss_d      = miss_q;
        sync_d      = 1'b0;
        peak_mag_d  = peak_mag_q;
        peak_off_d  = peak_off_q;
        locked_d    = locked_q;
        w_acq_close = 1'b0;

        w_hit      = (w_mag >= thresh);
        w_better   = (w_mag > best_q);
        w_wcnt_inc = wcnt_q + 1'b1;
        w_cnt_inc  = cnt_q + 1'b1;
        w_off_inc  = off_q + 1'b1;
        w_miss_inc = miss_q + 1'b1;

        if (stop) begin
            state_d  = IDLE;
            pk_d     = 1'b0;
            found_d  = 1'b0;
            miss_d   = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = ACQ;
                        pk_d    = 1'b0;
                    end
                end

                ACQ: begin
                    if (w_mag_v) begin
                        if (!pk_q) begin
                            // Trigger sample opens the search and is the
                            // first of the WIN samples searched.
                            if (w_hit) begin
                                pk_d        = 1'b1;
                                best_d      = w_mag;
                                off_d       = '0;
                                wcnt_d      = {{(CNT_W-1){1'b0}}, 1'b1};
                                w_acq_close = (WIN_C == {{(CNT_W-1){1'b0}}, 1'b1});
                            end
                        end else begin
                            wcnt_d = w_wcnt_inc;
                            if (w_better) begin
                                best_d = w_mag;
                                off_d  = '0;
                            end else begin
                                off_d  = w_off_inc;
                            end
                            w_acq_close = (w_wcnt_inc == WIN_C);
                        end
                        if (w_acq_close) begin
                            sync_d     = 1'b1;
                            peak_mag_d = best_d;
                            peak_off_d = off_d;
                            cnt_d      = off_d;
                            miss_d     = '0;
                            pk_d       = 1'b0;
                            locked_d   = 1'b1;
                            state_d    = TRACK;
                        end
                    end
                end

                TRACK: begin
                    // cnt is the distance in valid samples from the last
                    // (real or expected) peak.
                    if (w_mag_v) begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == TRACK_END_C) begin
                            state_d = TWIN;
                            best_d  = '0;
                            found_d = 1'b0;
                            wcnt_d  = '0;
                            off_d   = '0;
                        end
                    end
                end

                TWIN: begin
                    if (w_mag_v) begin
                        wcnt_d = w_wcnt_inc;
                        if (w_hit && w_better) begin
                            best_d  = w_mag;
                            off_d   = '0;
                            found_d = 1'b1;
                        end else begin
                            off_d   = w_off_inc;
                        end
                        if (w_wcnt_inc == TWIN_LEN_C) begin
                            if (found_d) begin
                                sync_d     = 1'b1;
                                peak_mag_d = best_d;
                                peak_off_d = off_d;
                                cnt_d      = off_d;
                                miss_d     = '0;
                                state_d    = TRACK;
                            end else begin
                                // Window closed WIN samples after the
                                // expected peak: keep the frame grid.
                                cnt_d = WIN_C;
                                if (w_miss_inc == MISS_C) begin
                                    miss_d   = '0;
                                    pk_d     = 1'b0;
                                    locked_d = 1'b0;
                                    state_d  = ACQ;
                                end else begin
                                    miss_d   = w_miss_inc;
                                    state_d  = TRACK;
                                end
                            end
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pk_q       <= 1'b0;
            found_q    <= 1'b0;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            off_q      <= '0;
            best_q     <= '0;
            miss_q     <= '0;
            sync_q     <= 1'b0;
            peak_mag_q <= '0;
            peak_off_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pk_q       <= pk_d;
            found_q    <= found_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            off_q      <= off_d;
            best_q     <= best_d;
            miss_q     <= miss_d;
            sync_q     <= sync_d;
            peak_mag_q <= peak_mag_d;
            peak_off_q <= peak_off_d;
            locked_q   <= locked_d;
        end
    end

    assign mf_en    = x_valid & (state_q != IDLE);
    assign sync     = sync_q;
    assign peak_mag = peak_mag_q;
    assign peak_off = peak_off_q;
    assign locked   = locked_q;
    assign state_o  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mf_peak_sync_ctrl.sv
// ============================================================================
//  Module   : tb_mf_peak_sync_ctrl
//  Purpose  : Directed self-checking bench for mf_peak_sync_ctrl. Expected
//             sync events (magnitude, offset) are queued as peaks are
//             scheduled and compared when the DUT pulses sync.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mf_peak_sync_ctrl;

    localparam int W3        = 32;
    localparam int FRAME_LEN = 4096;
    localparam int WIN       = 16;
    localparam int MISS_MAX  = 3;
    localparam int CNT_W     = 16;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             start   = 1'b0;
    logic             stop    = 1'b0;
    logic             x_valid = 1'b0;
    logic             mf_en_o = 1'b0;
    logic [W3:0]      thresh  = '0;
    logic [W3-1:0]    y_re    = '0;
    logic [W3-1:0]    y_im    = '0;
    wire              mf_en;
    wire              sync;
    wire  [W3:0]      peak_mag;
    wire  [CNT_W-1:0] peak_off;
    wire              locked;
    wire  [1:0]       state_o;

    mf_peak_sync_ctrl #(
        .W3        (W3),
        .FRAME_LEN (FRAME_LEN),
        .WIN       (WIN),
        .MISS_MAX  (MISS_MAX),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .x_valid  (x_valid),
        .mf_en    (mf_en),
        .thresh   (thresh),
        .y_re     (y_re),
        .y_im     (y_im),
        .mf_en_o  (mf_en_o),
        .sync     (sync),
        .peak_mag (peak_mag),
        .peak_off (peak_off),
        .locked   (locked),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint mag;
        longint off;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   sync_seen = 0;
    int   sync_exp  = 0;
    int   smp       = 0;
    int   sign_ph   = 0;
    bit   gaps      = 1'b0;
    int   pk_mag[int];
    int   p0, p1, p2, p3, p4, e5, pa, pb;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic expect_sync(input longint m, input longint o);
        exp_t e;
        e.mag = m;
        e.off = o;
        exp_q.push_back(e);
        sync_exp++;
    endtask

    // One valid MF sample of magnitude m, sign pattern rotated so both
    // absolute-value paths are exercised.
    task automatic send(input int m);
        int a, b;
        a = m / 2;
        b = m - a;
        @(negedge clk);
        case (sign_ph % 4)
            0:       begin y_re = a;  y_im = b;  end
            1:       begin y_re = -a; y_im = b;  end
            2:       begin y_re = a;  y_im = -b; end
            default: begin y_re = -a; y_im = -b; end
        endcase
        sign_ph++;
        mf_en_o = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mf_en_o = 1'b0;
        end
    endtask

    // Stream valid samples up to (not including) global index target.
    task automatic stream_to(input int target);
        int m;
        while (smp < target) begin
            m = pk_mag.exists(smp) ? pk_mag[smp] : (100 + (smp % 50));
            send(m);
            smp++;
            if (gaps && (smp % 7 == 3)) idle(5);
        end
        idle(1);
    endtask

    task automatic pulse(input bit do_start, input bit do_stop);
        @(negedge clk);
        mf_en_o = 1'b0;
        start   = do_start;
        stop    = do_stop;
        @(negedge clk);
        start   = 1'b0;
        stop    = 1'b0;
    endtask

    // Scoreboard side: each sync pops the oldest expected peak.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && sync === 1'b1) begin
            sync_seen++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sync_peak_mag", 64'(peak_mag), e.mag);
                check("sync_peak_off", 64'(peak_off), e.off);
                check("sync_locked", 64'(locked), 64'd1);
            end
        end
    end

    initial begin
        thresh  = 33'd400;
        x_valid = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_mf_en", 64'(mf_en), 64'd0);
        check("rst_sync", 64'(sync), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_peak_mag", 64'(peak_mag), 64'd0);
        check("rst_peak_off", 64'(peak_off), 64'd0);
        rst_n = 1'b1;

        // start and stop together in IDLE: stop wins
        pulse(1'b1, 1'b1);
        check("ss_state", 64'(state_o), 64'd0);
        check("ss_mf_en", 64'(mf_en), 64'd0);

        // Acquisition: 500,900,900,700 -> earliest 900, off 14
        pulse(1'b1, 1'b0);
        check("acq_state", 64'(state_o), 64'd1);
        check("acq_mf_en", 64'(mf_en), 64'd1);
        p0 = smp + 4;
        pk_mag[p0 - 1] = 500;
        pk_mag[p0]     = 900;
        pk_mag[p0 + 1] = 900;
        pk_mag[p0 + 2] = 700;
        expect_sync(900, 14);
        stream_to(p0 + 20);
        check("acq_sync_count", 64'(sync_seen), 64'(sync_exp));
        check("acq_locked", 64'(locked), 64'd1);
        check("acq_state_track", 64'(state_o), 64'd2);

        // Tracking with jitter
        p1 = p0 + FRAME_LEN + 3;
        pk_mag[p1 - 13] = 500;
        pk_mag[p1]      = 1000;
        expect_sync(1000, WIN - 3);
        p2 = p1 + FRAME_LEN - 5;
        pk_mag[p2]     = 1200;
        pk_mag[p2 + 2] = 1200;
        expect_sync(1200, WIN + 5);
        p3 = p2 + FRAME_LEN;
        pk_mag[p3]     = 800;
        pk_mag[p3 + 4] = 450;
        expect_sync(800, WIN);
        stream_to(p3 + WIN + 4);
        check("trk_sync_count", 64'(sync_seen), 64'(sync_exp));
        check("trk_locked", 64'(locked), 64'd1);

        // Same frame pattern as the first tracked frame, now with gaps
        gaps = 1'b1;
        p4 = p3 + FRAME_LEN + 3;
        pk_mag[p4 - 13] = 500;
        pk_mag[p4]      = 1000;
        expect_sync(1000, WIN - 3);
        stream_to(p4 + WIN + 4);
        gaps = 1'b0;
        check("gap_sync_count", 64'(sync_seen), 64'(sync_exp));

        // stop inside the tracking window: IDLE, unlocked, no sync
        e5 = p4 + FRAME_LEN;
        stream_to(e5 - WIN + 5);
        check("twin_state", 64'(state_o), 64'd3);
        pulse(1'b0, 1'b1);
        check("stop_state", 64'(state_o), 64'd0);
        check("stop_locked", 64'(locked), 64'd0);
        idle(10);
        check("stop_sync_count", 64'(sync_seen), 64'(sync_exp));

        // Lock again, then remove peaks: three misses back to ACQ
        pulse(1'b1, 1'b0);
        pa = smp + 2;
        pk_mag[pa] = 600;
        expect_sync(600, WIN - 1);
        stream_to(pa + FRAME_LEN + WIN + 20);
        check("miss1_state", 64'(state_o), 64'd2);
        check("miss1_locked", 64'(locked), 64'd1);
        check("miss1_sync_count", 64'(sync_seen), 64'(sync_exp));
        stream_to(pa + 2 * FRAME_LEN + WIN + 20);
        check("miss2_state", 64'(state_o), 64'd2);
        stream_to(pa + 3 * FRAME_LEN + WIN + 20);
        check("miss3_state", 64'(state_o), 64'd1);
        check("miss3_locked", 64'(locked), 64'd0);
        check("miss3_sync_count", 64'(sync_seen), 64'(sync_exp));

        // Reacquire, then asynchronous reset mid-TRACK
        pb = smp + 2;
        pk_mag[pb] = 700;
        expect_sync(700, WIN - 1);
        stream_to(pb + WIN + 100);
        check("pre_rst_state", 64'(state_o), 64'd2);
        check("pre_rst_sync_count", 64'(sync_seen), 64'(sync_exp));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_state", 64'(state_o), 64'd0);
        check("arst_mf_en", 64'(mf_en), 64'd0);
        check("arst_locked", 64'(locked), 64'd0);
        check("arst_sync", 64'(sync), 64'd0);
        check("arst_peak_mag", 64'(peak_mag), 64'd0);
        check("arst_peak_off", 64'(peak_off), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        check("end_state", 64'(state_o), 64'd0);
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
